// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: instruction fields, ALU flags and memory handshake in; datapath controls out.
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 4,
    parameter int STATE_W = 4
);
    logic [6:0] op;
    logic [2:0] funct3;
    logic funct7b5, zero, neg, ovf, carry, mem_ready;
    logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [STATE_W-1:0] state;
    modport master(
        output op, funct3, funct7b5, zero, neg, ovf, carry, mem_ready,
        input pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr,
        input result_src, alu_src_a, alu_src_b, imm_src, alu_control, state
    );
    modport slave(
        input op, funct3, funct7b5, zero, neg, ovf, carry, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr,
        output result_src, alu_src_a, alu_src_b, imm_src, alu_control, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM controller for a multicycle RISC-V datapath.
// CTRL_FULL_BRANCH_EN enables blt/bge/bltu/bgeu; without it only beq/bne are legal.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 4,
    parameter int STATE_W = 4
) (
    input logic clk,
    input logic reset,
    multicycle_control_unit_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, TRAP
    } state_t;
    state_t st, nx;
    logic [3:0] fn, alu;
    logic taken, br_ok;
    always_ff @(posedge clk) st <= reset ? FETCH : nx;
    // sub only for R-type (op[5]); I-type reuses funct7b5 solely to pick srai
    always_comb begin
        fn = 4'd2;
        case (bus.funct3)
            3'b000: fn = (bus.op[5] && bus.funct7b5) ? 4'd1 : 4'd0;
            3'b001: fn = 4'd7;
            3'b010: fn = 4'd5;
            3'b011: fn = 4'd6;
            3'b100: fn = 4'd4;
            3'b101: fn = bus.funct7b5 ? 4'd9 : 4'd8;
            3'b110: fn = 4'd3;
            default: fn = 4'd2;
        endcase
    end
`ifdef CTRL_FULL_BRANCH_EN
    always_comb begin
        br_ok = 1'b1;
        taken = 1'b0;
        case (bus.funct3)
            3'b000: taken = bus.zero;
            3'b001: taken = !bus.zero;
            3'b100: taken = bus.neg ^ bus.ovf;
            3'b101: taken = !(bus.neg ^ bus.ovf);
            3'b110: taken = !bus.carry;
            3'b111: taken = bus.carry;
            default: taken = 1'b0;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = ^{bus.neg, bus.ovf, bus.carry};
    assign br_ok = bus.funct3[2:1] == 2'b00;
    assign taken = bus.funct3[0] ? !bus.zero : bus.zero;
`endif
    always_comb begin
        nx = st;
        alu = 4'd0;
        bus.pc_write = 1'b0;
        bus.adr_src = 1'b0;
        bus.mem_write = 1'b0;
        bus.ir_write = 1'b0;
        bus.reg_write = 1'b0;
        bus.illegal_instr = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a = 2'b00;
        bus.alu_src_b = 2'b00;
        bus.imm_src = 2'b00;
        case (st)
            FETCH: begin
                bus.alu_src_b = 2'b10;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
                bus.result_src = 2'b10;
                nx = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                bus.imm_src = 2'b10;
                case (bus.op)
                    7'b0000011, 7'b0100011: nx = MEMADR;
                    7'b0110011: nx = EXECUTER;
                    7'b0010011: nx = EXECUTEI;
                    7'b1100011: nx = br_ok ? BRANCH : TRAP;
                    7'b1101111: nx = JAL;
                    default: nx = TRAP;
                endcase
            end
            MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.imm_src = bus.op[5] ? 2'b01 : 2'b00;
                nx = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.adr_src = 1'b1;
                nx = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                bus.reg_write = 1'b1;
                bus.result_src = 2'b01;
                nx = FETCH;
            end
            MEMWRITE: begin
                bus.adr_src = 1'b1;
                bus.mem_write = 1'b1;
                nx = bus.mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                bus.alu_src_a = 2'b10;
                alu = fn;
                nx = ALUWB;
            end
            EXECUTEI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                alu = fn;
                nx = ALUWB;
            end
            ALUWB: begin
                bus.reg_write = 1'b1;
                nx = FETCH;
            end
            JAL: begin
                bus.pc_write = 1'b1;
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                nx = ALUWB;
            end
            BRANCH: begin
                bus.alu_src_a = 2'b10;
                alu = 4'd1;
                bus.pc_write = taken;
                nx = FETCH;
            end
            TRAP: bus.illegal_instr = 1'b1;
            default: nx = FETCH;
        endcase
        if (reset) begin
            bus.pc_write = 1'b0;
            bus.mem_write = 1'b0;
            bus.ir_write = 1'b0;
            bus.reg_write = 1'b0;
            bus.illegal_instr = 1'b0;
        end
        bus.alu_control = ALU_CTRL_W'(alu);
        bus.state = STATE_W'(st);
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed instruction walks with hand-computed state and control values.
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    multicycle_control_unit_if #(.ALU_CTRL_W(4), .STATE_W(4)) bus();
    multicycle_control_unit #(.ALU_CTRL_W(4), .STATE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    int n_checks = 0;
    int n_fail = 0;
    int rw_cnt = 0;
    int mw_cnt = 0;
    int base_rw, base_mw;
    wire [3:0] en = {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write};
    always @(negedge clk) begin
        if (bus.reg_write) rw_cnt++;
        if (bus.mem_write) mw_cnt++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        bus.op = o;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
    endtask
    task automatic run_exec(input string tag, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic [3:0] es, input logic [3:0] ea);
        set_instr(o, f3, f7);
        bus.mem_ready = 1'b1;
        step();
        step();
        #1;
        check({tag, "_state"}, bus.state, es);
        check({tag, "_alu"}, bus.alu_control, ea);
        step();
        #1;
        check({tag, "_wb"}, {bus.state, en}, {4'd8, 4'b0001});
        step();
    endtask
    initial begin
        set_instr(7'b0, 3'b0, 1'b0);
        {bus.zero, bus.neg, bus.ovf, bus.carry} = 4'b0;
        bus.mem_ready = 1'b1;
        step();
        step();
        #1;
        check("rst_state", bus.state, 0);
        check("rst_en", en, 0);
        check("rst_ill", bus.illegal_instr, 0);
        // lw: two wait cycles in FETCH, one in MEMREAD
        reset = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0);
        bus.mem_ready = 1'b0;
        base_rw = rw_cnt;
        #1;
        check("lw_f0", {bus.state, en}, {4'd0, 4'b0000});
        step();
        #1;
        check("lw_f1", bus.state, 0);
        step();
        bus.mem_ready = 1'b1;
        #1;
        check("lw_f2", {bus.state, en}, {4'd0, 4'b1100});
        check("lw_f2_srcb", {bus.alu_src_a, bus.alu_src_b}, 4'b0010);
        step();
        #1;
        check("lw_dec", bus.state, 1);
        check("lw_dec_ctl", {bus.alu_src_a, bus.alu_src_b, bus.imm_src, en}, {6'b010110, 4'b0000});
        step();
        bus.mem_ready = 1'b0;
        #1;
        check("lw_adr", {bus.state, bus.alu_src_a, bus.imm_src}, {4'd2, 2'b10, 2'b00});
        step();
        #1;
        check("lw_rd0", {bus.state, bus.adr_src}, {4'd3, 1'b1});
        step();
        bus.mem_ready = 1'b1;
        #1;
        check("lw_rd1", bus.state, 3);
        step();
        #1;
        check("lw_wb", {bus.state, en, bus.result_src}, {4'd4, 4'b0001, 2'b01});
        step();
        #1;
        check("lw_done", bus.state, 0);
        check("lw_rw_pulses", rw_cnt - base_rw, 1);
        // sw with mem_ready held high
        set_instr(7'b0100011, 3'b010, 1'b0);
        base_rw = rw_cnt;
        base_mw = mw_cnt;
        step();
        #1;
        check("sw_dec", bus.state, 1);
        step();
        #1;
        check("sw_adr", {bus.state, bus.imm_src}, {4'd2, 2'b01});
        step();
        #1;
        check("sw_wr", {bus.state, en, bus.adr_src}, {4'd5, 4'b0010, 1'b1});
        step();
        #1;
        check("sw_done", bus.state, 0);
        check("sw_mw_pulses", mw_cnt - base_mw, 1);
        check("sw_no_rw", rw_cnt - base_rw, 0);
        run_exec("sub", 7'b0110011, 3'b000, 1'b1, 4'd6, 4'd1);
        run_exec("addi", 7'b0010011, 3'b000, 1'b1, 4'd7, 4'd0);
        run_exec("add", 7'b0110011, 3'b000, 1'b0, 4'd6, 4'd0);
        run_exec("sra", 7'b0110011, 3'b101, 1'b1, 4'd6, 4'd9);
        run_exec("srai", 7'b0010011, 3'b101, 1'b1, 4'd7, 4'd9);
        run_exec("srli", 7'b0010011, 3'b101, 1'b0, 4'd7, 4'd8);
        run_exec("xori", 7'b0010011, 3'b100, 1'b0, 4'd7, 4'd4);
        run_exec("and", 7'b0110011, 3'b111, 1'b0, 4'd6, 4'd2);
        run_exec("sltu", 7'b0110011, 3'b011, 1'b0, 4'd6, 4'd6);
        run_exec("sll", 7'b0110011, 3'b001, 1'b0, 4'd6, 4'd7);
        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        step();
        step();
        #1;
        check("jal_state", {bus.state, en}, {4'd10, 4'b1000});
        check("jal_src", {bus.alu_src_a, bus.alu_src_b, bus.result_src}, 6'b011000);
        step();
        #1;
        check("jal_wb", {bus.state, en}, {4'd8, 4'b0001});
        step();
        // beq taken / not taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        bus.zero = 1'b1;
        step();
        step();
        #1;
        check("beq_t", {bus.state, bus.pc_write, bus.alu_control}, {4'd9, 1'b1, 4'd1});
        step();
        #1;
        check("beq_t_done", bus.state, 0);
        bus.zero = 1'b0;
        step();
        step();
        #1;
        check("beq_nt", {bus.state, bus.pc_write}, {4'd9, 1'b0});
        step();
        // blt with neg=1, ovf=0
        set_instr(7'b1100011, 3'b100, 1'b0);
        bus.neg = 1'b1;
        step();
        step();
        #1;
`ifdef CTRL_FULL_BRANCH_EN
        check("blt_taken", {bus.state, bus.pc_write}, {4'd9, 1'b1});
        step();
`else
        check("blt_trap", {bus.state, bus.illegal_instr}, {4'd11, 1'b1});
        reset = 1'b1;
        step();
        reset = 1'b0;
`endif
        bus.neg = 1'b0;
        #1;
        check("blt_after", bus.state, 0);
        // illegal opcode traps until reset
        set_instr(7'b0000000, 3'b000, 1'b0);
        step();
        step();
        #1;
        check("ill_trap", {bus.state, bus.illegal_instr}, {4'd11, 1'b1});
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = i[0];
            step();
            #1;
            check("ill_hold", {bus.state, en, bus.illegal_instr}, {4'd11, 4'b0000, 1'b1});
        end
        reset = 1'b1;
        step();
        #1;
        check("ill_rst", {bus.state, bus.illegal_instr}, {4'd0, 1'b0});
        // reset while waiting in MEMREAD
        reset = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0);
        bus.mem_ready = 1'b1;
        step();
        step();
        bus.mem_ready = 1'b0;
        step();
        #1;
        check("mr_wait", bus.state, 3);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        step();
        #1;
        check("mr_rst_state", bus.state, 0);
        check("mr_rst_en", {en, bus.illegal_instr}, 5'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
